sw_debounce: RTL and testbench
==============================

Name: sw_debounce

Overview:
- Input-conditioning stage that sits directly upstream of the combinational x/y logic block (the one with inputs a, b, c and outputs x, y).
- Takes raw board slide-switch/push-button levels, which are asynchronous and bouncing.
- Synchronises each input to clk, debounces it with a per-channel counter FSM, and drives clean levels plus one-cycle edge pulses.
- Board wiring: sw_db[2] to a, sw_db[1] to b, sw_db[0] to c.

Parameters:
- WIDTH, 3, number of independent input channels.
- SYNC_STAGES, 2, synchroniser flop depth per channel (minimum 2).
- CNT_MAX, 1000000, consecutive clk cycles a new level must persist before it is accepted (10 ms at 100 MHz). Minimum 2.
- CNT_W, $clog2(CNT_MAX), derived counter width. Not overridden by users.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- sw_raw  in  WIDTH  raw asynchronous switch levels.
- sw_db  out  WIDTH  debounced stable levels.
- sw_rise  out  WIDTH  one-cycle pulse when sw_db[i] goes 0→1.
- sw_fall  out  WIDTH  one-cycle pulse when sw_db[i] goes 1→0.
- any_change  out  1  OR of all sw_rise and sw_fall bits, same cycle.

Behaviour:
- Interface: one clock (clk). Reset rst is synchronous and active-high, sampled only on the rising edge of clk.
- Reset:
  - All synchroniser flops clear to 0.
  - sw_db = 0, sw_rise = 0, sw_fall = 0, any_change = 0.
  - Every channel FSM goes to STABLE with cnt = 0.
- Synchroniser: sw_raw[i] passes through SYNC_STAGES flops. The last stage is sw_sync[i]. No logic between stages.
- Per-channel FSM, states STABLE and WAIT:
  - STABLE:
    - If sw_sync ≠ sw_db: go to WAIT, cnt ← 1.
    - Otherwise stay, cnt ← 0.
  - WAIT, sw_sync == sw_db (bounce back): go to STABLE, cnt ← 0, sw_db unchanged, no pulse.
  - WAIT, sw_sync ≠ sw_db and cnt == CNT_MAX−1:
    - sw_db ← ~sw_db.
    - Assert the matching rise/fall pulse for exactly the next cycle.
    - Go to STABLE, cnt ← 0.
  - WAIT, otherwise: cnt ← cnt + 1.
- Latency:
  - sw_sync must differ from sw_db on CNT_MAX consecutive rising edges.
  - sw_db flips on the CNT_MAX-th of those edges.
  - Raw-to-sw_db latency = SYNC_STAGES + CNT_MAX cycles (fixed, for a clean edge).
- Outputs: sw_db, sw_rise, sw_fall and any_change are all registered. There is no combinational path from sw_raw to any output.
- Pulses:
  - sw_rise[i] and sw_fall[i] are never high together and never high for two consecutive cycles.
  - A new edge on the same channel needs at least CNT_MAX further cycles.
- Channels are fully independent. Simultaneous acceptance on several channels asserts several pulse bits in the same cycle, with any_change = 1 once.
- Bounce: any glitch shorter than CNT_MAX cycles, as seen at sw_sync, leaves sw_db unchanged and produces no pulse. Each return to the old level restarts the count from 0.
- Counter: cnt never exceeds CNT_MAX−1 and never wraps. In STABLE it is held at 0.
- Reset mid-count: a pending WAIT is abandoned and sw_db returns to 0, even if it was 1. After reset is released, an input held at 1 is re-accepted after SYNC_STAGES + CNT_MAX cycles with a sw_rise pulse.
- The reset value of 0 for sw_db is fixed, not parameterised.

Decomposition:
- debounce_pkg holds:
  - typedef enum logic {STABLE, WAIT} db_state_t.
  - localparam DEF_CNT_MAX = 1000000.
  - localparam DEF_SYNC_STAGES = 2.
- Sub-module db_channel (parameters SYNC_STAGES, CNT_MAX) contains one synchroniser, FSM and counter, with outputs db, rise, fall.
- sw_debounce instantiates WIDTH copies with a generate loop and ORs the pulses into any_change.

Test Plan (bench uses CNT_MAX=4, SYNC_STAGES=2):
- Reset: hold rst=1 for 3 cycles with sw_raw=3'b111 → all outputs 0 during reset. After release, sw_db=3'b111 exactly 6 cycles later, with sw_rise=3'b111 and any_change=1 for that one cycle only.
- Clean edge: sw_raw[1] 0→1 and held → sw_db[1] rises on the 6th edge after the change. sw_rise[1]=1 for 1 cycle, sw_fall=0.
- Bounce rejection: sw_raw[0] toggles 1,0,1,0 every 2 cycles, then stays 0 → sw_db[0] stays 0, no pulses. Then hold sw_raw[0]=1 → accepted 6 cycles after the last transition.
- Release: sw_db[2]=1, then sw_raw[2]→0 → sw_db[2]=0 after 6 cycles, with a single sw_fall[2] pulse.
- Simultaneous: sw_raw 3'b000→3'b101 in one cycle → sw_db=3'b101 on the same edge, sw_rise=3'b101, any_change=1 for one cycle.
- Reset mid-count: assert rst when cnt=2 on channel 1 → sw_db=0, no pulse. Count restarts from 0 after rst is released.

Source files
------------

// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared types and defaults for the switch debouncer
//
// Purpose : per-channel FSM state encoding and default parameter values
//           used by db_channel and sw_debounce.
// Ports   : none (package).
package debounce_pkg;

  // STABLE: debounced level matches the synchronised input.
  // WAIT  : synchronised input differs; counting how long it has persisted.
  typedef enum logic {
    STABLE = 1'b0,
    WAIT   = 1'b1
  } db_state_t;

  // 10 ms at 100 MHz.
  localparam int DEF_CNT_MAX     = 1000000;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_WIDTH       = 3;

endpackage : debounce_pkg

// File: rtl/db_channel.sv
// rtl/db_channel.sv - one synchroniser + debounce FSM + counter for a single switch
//
// Purpose : bring one raw asynchronous switch level into the clk domain,
//           accept a new level only after it has persisted for CNT_MAX
//           consecutive cycles, and flag the accepted edge with a pulse.
// Ports   : i_clk  - system clock, rising edge
//           i_rst  - synchronous reset, active-high
//           i_raw  - raw asynchronous switch level
//           o_db   - debounced level (registered, resets to 0)
//           o_rise - one-cycle pulse when o_db goes 0->1 (registered)
//           o_fall - one-cycle pulse when o_db goes 1->0 (registered)
module db_channel
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int CNT_MAX     = DEF_CNT_MAX
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_raw,
  output logic o_db,
  output logic o_rise,
  output logic o_fall
);

  localparam int CNT_W = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Synchroniser chain: plain flop-to-flop, no logic between stages.
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_sync;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
    end
  end

  assign w_sync = r_sync[SYNC_STAGES-1];

  // FSM, counter and output registers.
  db_state_t        r_state;
  db_state_t        w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_db;
  logic             w_db_nxt;
  logic             r_rise;
  logic             w_rise_nxt;
  logic             r_fall;
  logic             w_fall_nxt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= STABLE;
      r_cnt   <= '0;
      r_db    <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_db    <= w_db_nxt;
      r_rise  <= w_rise_nxt;
      r_fall  <= w_fall_nxt;
    end
  end

  // The counter is zero whenever the FSM is (or returns to) STABLE, so a
  // bounce back to the old level always restarts the qualification window.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = '0;
    w_db_nxt    = r_db;
    w_rise_nxt  = 1'b0;
    w_fall_nxt  = 1'b0;

    case (r_state)
      STABLE: begin
        if (w_sync != r_db) begin
          w_state_nxt = WAIT;
          w_cnt_nxt   = CNT_ONE;
        end
      end

      WAIT: begin
        if (w_sync == r_db) begin
          w_state_nxt = STABLE;
        end else if (r_cnt == CNT_LAST) begin
          // CNT_MAX-th consecutive differing edge: accept the new level.
          w_state_nxt = STABLE;
          w_db_nxt    = ~r_db;
          w_rise_nxt  = ~r_db;
          w_fall_nxt  = r_db;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end

      default: begin
        w_state_nxt = STABLE;
      end
    endcase
  end

  assign o_db   = r_db;
  assign o_rise = r_rise;
  assign o_fall = r_fall;

endmodule : db_channel

// File: rtl/sw_debounce.sv
// rtl/sw_debounce.sv - multi-channel switch/button synchroniser and debouncer
//
// Purpose : conditions WIDTH raw board switch levels into clean debounced
//           levels plus one-cycle edge pulses. Board wiring: sw_db[2] -> a,
//           sw_db[1] -> b, sw_db[0] -> c of the downstream x/y logic.
// Ports   : clk        - system clock, rising edge
//           rst        - synchronous reset, active-high
//           sw_raw     - raw asynchronous switch levels   [WIDTH]
//           sw_db      - debounced stable levels          [WIDTH]
//           sw_rise    - one-cycle 0->1 pulse per channel [WIDTH]
//           sw_fall    - one-cycle 1->0 pulse per channel [WIDTH]
//           any_change - OR of all rise/fall bits, same cycle
module sw_debounce
  import debounce_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int CNT_MAX     = DEF_CNT_MAX
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_db,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             any_change
);

  genvar g;
  generate
    for (g = 0; g < WIDTH; g++) begin : g_ch
      db_channel #(
        .SYNC_STAGES(SYNC_STAGES),
        .CNT_MAX    (CNT_MAX)
      ) u_ch (
        .i_clk (clk),
        .i_rst (rst),
        .i_raw (sw_raw[g]),
        .o_db  (sw_db[g]),
        .o_rise(sw_rise[g]),
        .o_fall(sw_fall[g])
      );
    end
  endgenerate

  // Pulses are already registered per channel, so this OR adds no path
  // from sw_raw and lines up with the pulse bits in the same cycle.
  logic [WIDTH-1:0] w_pulse;
  assign w_pulse    = sw_rise | sw_fall;
  assign any_change = |w_pulse;

endmodule : sw_debounce

// File: tb/tb_sw_debounce.sv
// tb/tb_sw_debounce.sv - directed self-checking bench for sw_debounce
module tb_sw_debounce;

  localparam int WIDTH = 3;
  localparam int SYNC  = 2;
  localparam int CMAX  = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] sw_raw;
  logic [WIDTH-1:0] sw_db;
  logic [WIDTH-1:0] sw_rise;
  logic [WIDTH-1:0] sw_fall;
  logic             any_change;

  always #5 clk = ~clk;

  sw_debounce #(
    .WIDTH      (WIDTH),
    .SYNC_STAGES(SYNC),
    .CNT_MAX    (CMAX)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sw_raw    (sw_raw),
    .sw_db     (sw_db),
    .sw_rise   (sw_rise),
    .sw_fall   (sw_fall),
    .any_change(any_change)
  );

  typedef struct {
    logic             rst;
    logic [WIDTH-1:0] raw;
    logic [WIDTH-1:0] db;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
  } vec_t;

  vec_t vq[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic cmp(input string name, input int idx,
                     input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %b expected %b", name, idx, act, exp);
    end
  endtask

  // Drive one cycle of inputs, let one rising edge pass, then sample 1 ns later.
  task automatic step(input string tag, input int idx, input logic r,
                      input logic [WIDTH-1:0] raw, input logic [WIDTH-1:0] db,
                      input logic [WIDTH-1:0] rise, input logic [WIDTH-1:0] fall);
    logic [WIDTH-1:0] exp_any;
    rst    = r;
    sw_raw = raw;
    @(posedge clk);
    #1;
    exp_any = {{(WIDTH-1){1'b0}}, |(rise | fall)};
    cmp({tag, " sw_db"},      idx, sw_db,   db);
    cmp({tag, " sw_rise"},    idx, sw_rise, rise);
    cmp({tag, " sw_fall"},    idx, sw_fall, fall);
    cmp({tag, " any_change"}, idx, {{(WIDTH-1){1'b0}}, any_change}, exp_any);
  endtask

  task automatic add(input logic r, input logic [WIDTH-1:0] raw,
                     input logic [WIDTH-1:0] db, input logic [WIDTH-1:0] rise,
                     input logic [WIDTH-1:0] fall, input int n);
    for (int i = 0; i < n; i++) vq.push_back('{r, raw, db, rise, fall});
  endtask

  // Raw level applied and held: old level for SYNC+CMAX-1 edges, new level
  // with the pulses on edge SYNC+CMAX, then two quiet cycles.
  task automatic seg(input logic [WIDTH-1:0] raw, input logic [WIDTH-1:0] old_db,
                     input logic [WIDTH-1:0] new_db);
    add(1'b0, raw, old_db, '0, '0, SYNC + CMAX - 1);
    add(1'b0, raw, new_db, new_db & ~old_db, old_db & ~new_db, 1);
    add(1'b0, raw, new_db, '0, '0, 2);
  endtask

  initial begin
    rst    = 1'b1;
    sw_raw = '0;

    // Reset with all switches high, then acceptance after release.
    add(1'b1, 3'b111, 3'b000, 3'b000, 3'b000, 3);
    seg(3'b111, 3'b000, 3'b111);
    // Release of channel 2 alone.
    seg(3'b011, 3'b111, 3'b011);
    // Channels 1 and 0 fall together.
    seg(3'b000, 3'b011, 3'b000);
    // Clean edge on channel 1 and its release.
    seg(3'b010, 3'b000, 3'b010);
    seg(3'b000, 3'b010, 3'b000);
    // Simultaneous rise on channels 2 and 0, then back.
    seg(3'b101, 3'b000, 3'b101);
    seg(3'b000, 3'b101, 3'b000);

    for (int i = 0; i < vq.size(); i++)
      step("table", i, vq[i].rst, vq[i].raw, vq[i].db, vq[i].rise, vq[i].fall);

    // Bounce on channel 0: high/low in 2-cycle runs, never CMAX long.
    begin
      logic [WIDTH-1:0] pat [8];
      pat = '{3'b001, 3'b001, 3'b000, 3'b000, 3'b001, 3'b001, 3'b000, 3'b000};
      for (int i = 0; i < 8; i++) step("bounce", i, 1'b0, pat[i], '0, '0, '0);
      for (int i = 0; i < 4; i++) step("bounce_settle", i, 1'b0, 3'b000, '0, '0, '0);
    end
    // Held high after the bounce: accepted on the 6th edge.
    for (int i = 0; i < SYNC + CMAX - 1; i++)
      step("bounce_hold", i, 1'b0, 3'b001, 3'b000, '0, '0);
    step("bounce_accept", 0, 1'b0, 3'b001, 3'b001, 3'b001, '0);
    step("bounce_quiet", 0, 1'b0, 3'b001, 3'b001, '0, '0);

    // Reset mid-count on channel 1 (cnt reaches 2 after 4 edges); sw_db[0]
    // also drops to 0 without a fall pulse.
    for (int i = 0; i < 4; i++)
      step("midcnt_pre", i, 1'b0, 3'b011, 3'b001, '0, '0);
    step("midcnt_rst", 0, 1'b1, 3'b011, 3'b000, '0, '0);
    for (int i = 0; i < SYNC + CMAX - 1; i++)
      step("midcnt_restart", i, 1'b0, 3'b011, 3'b000, '0, '0);
    step("midcnt_accept", 0, 1'b0, 3'b011, 3'b011, 3'b011, '0);
    step("midcnt_quiet", 0, 1'b0, 3'b011, 3'b011, '0, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_sw_debounce
